// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin memory bus arbiter with wait timeout
module bus_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        mem_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datao,
  output logic        mem_rw,
  input  logic [31:0] mem_data,
  input  logic        mem_ready
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic        owner_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_en_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_datao_q;
  logic        mem_rw_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        m0_done_q, m1_done_q;
  logic        m0_err_q, m1_err_q;

  logic        any_req_d;
  logic        grant_d;
  logic [7:0]  wait_cnt_d;
  logic        timeout_d;

  // Grant choice (0 = m0, 1 = m1): on a tie the master not granted last wins; wait counter lookahead
  always_comb begin
    any_req_d  = m0_req | m1_req;
    grant_d    = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    wait_cnt_d = wait_cnt_q + 8'd1;
    timeout_d  = (wait_cnt_d == MaxWait);
  end

  // Arbiter FSM: every output is a register written here
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      wait_cnt_q    <= 8'd0;
      mem_en_q      <= 1'b0;
      mem_address_q <= 32'd0;
      mem_datao_q   <= 32'd0;
      mem_rw_q      <= 1'b1;
      m0_rdata_q    <= 32'd0;
      m1_rdata_q    <= 32'd0;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
    end else begin
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q       <= BUSY;
            owner_q       <= grant_d;
            last_grant_q  <= grant_d;
            wait_cnt_q    <= 8'd0;
            mem_en_q      <= 1'b1;
            mem_address_q <= grant_d ? m1_addr : m0_addr;
            mem_datao_q   <= grant_d ? m1_wdata : m0_wdata;
            mem_rw_q      <= ~(grant_d ? m1_we : m0_we);
          end
        end
        BUSY: begin
          if (mem_ready) begin
            // Completion takes priority over a timeout landing on the same edge
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            if (owner_q) begin
              m1_done_q <= 1'b1;
              if (mem_rw_q) m1_rdata_q <= mem_data;
            end else begin
              m0_done_q <= 1'b1;
              if (mem_rw_q) m0_rdata_q <= mem_data;
            end
          end else if (timeout_d) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            wait_cnt_q <= wait_cnt_d;
            if (owner_q) begin
              m1_done_q  <= 1'b1;
              m1_err_q   <= 1'b1;
              m1_rdata_q <= 32'hFFFF_FFFF;
            end else begin
              m0_done_q  <= 1'b1;
              m0_err_q   <= 1'b1;
              m0_rdata_q <= 32'hFFFF_FFFF;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_address = mem_address_q;
  assign mem_datao   = mem_datao_q;
  assign mem_rw      = mem_rw_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_done     = m0_done_q;
  assign m1_done     = m1_done_q;
  assign m0_err      = m0_err_q;
  assign m1_err      = m1_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a transfer-level model
module tb_bus_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        we    [2];
  logic [31:0] mem_data;
  logic        mem_ready;

  logic [31:0] m0_rdata, m1_rdata, mem_address, mem_datao;
  logic        m0_done, m1_done, m0_err, m1_err, mem_en, mem_rw;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one in-flight transfer, who owns it and how long it has waited
  bit          x_busy;
  int          x_owner;
  int          x_last;
  int          x_waited;
  logic [31:0] x_addr, x_dout;
  logic        x_rw, x_en;
  logic        x_done  [2];
  logic        x_err   [2];
  logic [31:0] x_rdata [2];
  int          done_cnt [2];

  bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_we(we[0]),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_we(we[1]),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_en(mem_en), .mem_address(mem_address), .mem_datao(mem_datao), .mem_rw(mem_rw),
    .mem_data(mem_data), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    x_busy = 0; x_owner = 0; x_last = 1; x_waited = 0;
    x_addr = 0; x_dout = 0; x_rw = 1; x_en = 0;
    for (int i = 0; i < 2; i++) begin
      x_done[i] = 0; x_err[i] = 0; x_rdata[i] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_step();
    int pick;
    x_done[0] = 0; x_done[1] = 0; x_err[0] = 0; x_err[1] = 0;
    if (!x_busy) begin
      pick = -1;
      if (req[0] && req[1]) pick = (x_last == 0) ? 1 : 0;
      else if (req[0])      pick = 0;
      else if (req[1])      pick = 1;
      if (pick >= 0) begin
        x_busy = 1; x_owner = pick; x_last = pick; x_waited = 0; x_en = 1;
        x_addr = addr[pick]; x_dout = wdata[pick]; x_rw = !we[pick];
      end
    end else if (mem_ready) begin
      x_busy = 0; x_en = 0; x_done[x_owner] = 1;
      if (x_rw) x_rdata[x_owner] = mem_data;
    end else if (x_waited + 1 >= MAX_WAIT) begin
      x_busy = 0; x_en = 0; x_done[x_owner] = 1; x_err[x_owner] = 1;
      x_rdata[x_owner] = 32'hFFFF_FFFF;
    end else begin
      x_waited++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".mem_en"},   32'(mem_en),      32'(x_en));
    check({tag, ".mem_addr"}, mem_address,      x_addr);
    check({tag, ".mem_dout"}, mem_datao,        x_dout);
    check({tag, ".mem_rw"},   32'(mem_rw),      32'(x_rw));
    check({tag, ".m0_done"},  32'(m0_done),     32'(x_done[0]));
    check({tag, ".m1_done"},  32'(m1_done),     32'(x_done[1]));
    check({tag, ".m0_err"},   32'(m0_err),      32'(x_err[0]));
    check({tag, ".m1_err"},   32'(m1_err),      32'(x_err[1]));
    check({tag, ".m0_rdata"}, m0_rdata,         x_rdata[0]);
    check({tag, ".m1_rdata"}, m1_rdata,         x_rdata[1]);
    check({tag, ".one_done"}, 32'(m0_done & m1_done), 32'd0);
    if (m0_done) done_cnt[0]++;
    if (m1_done) done_cnt[1]++;
  endtask

  // One clock: model follows the edge, DUT sampled on the following falling edge
  task automatic cycle(input string tag);
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all(tag);
  endtask

  task automatic set_master(input int m, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic w);
    req[m] = r; addr[m] = a; wdata[m] = d; we[m] = w;
  endtask

  initial begin
    reset = 1'b0;
    set_master(0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0);
    mem_data = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all("reset");
    reset = 1'b1;

    // m0 read 0x10, ready on 2nd BUSY cycle
    set_master(0, 1, 32'h10, 32'h0, 0);
    cycle("rd.grant");
    check("rd.addr_const", mem_address, 32'h10);
    check("rd.rw_const", 32'(mem_rw), 32'd1);
    cycle("rd.busy1");
    mem_ready = 1; mem_data = 32'hDEADBEEF;
    req[0] = 0;
    cycle("rd.busy2");
    check("rd.rdata_const", m0_rdata, 32'hDEADBEEF);
    check("rd.done_const", 32'(m0_done), 32'd1);
    mem_ready = 0;
    cycle("rd.idle");

    // both masters held for 4 transfers, ready always 1
    done_cnt[0] = 0; done_cnt[1] = 0;
    set_master(0, 1, 32'hA0, 32'h1, 0);
    set_master(1, 1, 32'hB0, 32'h2, 0);
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      mem_data = 32'h100 + 32'(i);
      cycle("rr");
    end
    req[0] = 0; req[1] = 0; mem_ready = 0;
    cycle("rr.tail");
    check("rr.m0_count", 32'(done_cnt[0]), 32'd2);
    check("rr.m1_count", 32'(done_cnt[1]), 32'd2);

    // m1 write 0x20
    set_master(1, 1, 32'h20, 32'h12345678, 1);
    cycle("wr.grant");
    req[1] = 0;
    repeat (3) begin
      cycle("wr.busy");
      check("wr.rw_const", 32'(mem_rw), 32'd0);
      check("wr.dout_const", mem_datao, 32'h12345678);
    end
    mem_ready = 1; mem_data = 32'hCAFE0000;
    cycle("wr.done");
    mem_ready = 0;
    cycle("wr.idle");

    // timeout: m0 read with ready held low
    set_master(0, 1, 32'h40, 32'h0, 0);
    cycle("to.grant");
    req[0] = 0;
    for (int i = 0; i < MAX_WAIT; i++) cycle("to.busy");
    check("to.err_const", 32'(m0_err), 32'd1);
    check("to.rdata_const", m0_rdata, 32'hFFFFFFFF);
    check("to.en_const", 32'(mem_en), 32'd0);
    cycle("to.idle");

    // ready arriving on the very edge the counter would expire
    set_master(1, 1, 32'h44, 32'h0, 0);
    cycle("edge.grant");
    req[1] = 0;
    for (int i = 0; i < MAX_WAIT - 1; i++) cycle("edge.busy");
    mem_ready = 1; mem_data = 32'h55AA55AA;
    cycle("edge.done");
    check("edge.err_const", 32'(m1_err), 32'd0);
    mem_ready = 0;
    cycle("edge.idle");

    // reset mid-BUSY
    set_master(0, 1, 32'h60, 32'h0, 0);
    cycle("rst.grant");
    cycle("rst.busy");
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("rst.async");
    req[0] = 0;
    @(negedge clock);
    compare_all("rst.hold");
    reset = 1'b1;
    cycle("rst.nodone");
    set_master(1, 1, 32'h70, 32'h0, 0);
    cycle("rst.m1grant");
    req[1] = 0; mem_ready = 1; mem_data = 32'h0BADF00D;
    cycle("rst.m1done");
    mem_ready = 0;
    cycle("rst.idle");

    // req dropped on 1st BUSY cycle, ready on 3rd
    done_cnt[0] = 0;
    set_master(0, 1, 32'h80, 32'h0, 0);
    cycle("drop.grant");
    req[0] = 0;
    cycle("drop.busy1");
    cycle("drop.busy2");
    mem_ready = 1; mem_data = 32'h31415926;
    cycle("drop.busy3");
    mem_ready = 0;
    cycle("drop.idle");
    check("drop.count", 32'(done_cnt[0]), 32'd1);

    // randomized traffic, with stretches of stalled memory to reach the timeout
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++)
        set_master(m, 1'($urandom_range(0, 2) != 0), $urandom, $urandom, 1'($urandom));
      mem_data  = $urandom;
      mem_ready = ((i / 50) % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15: number of BUSY cycles without mem_ready before the transaction is aborted; legal range 1..255.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 m0_req  input  1  master 0 (CPU) transfer request, level, held until m0_done.
REQ-005 m0_addr  input  32  master 0 word address.
REQ-006 m0_wdata  input  32  master 0 write data.
REQ-007 m0_we  input  1  master 0 write enable (1=write, 0=read).
REQ-008 m0_rdata  output  32  master 0 read data, valid while m0_done=1.
REQ-009 m0_done  output  1  master 0 completion pulse, one cycle.
REQ-010 m0_err  output  1  master 0 timeout flag, valid while m0_done=1.
REQ-011 m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_done, m1_err: same directions, widths and meaning as the m0_ ports, for master 1 (DMA/IO).
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_address  output  32  memory address.
REQ-014 mem_datao  output  32  memory write data.
REQ-015 mem_rw  output  1  1=read, 0=write.
REQ-016 mem_data  input  32  memory read data.
REQ-017 mem_ready  input  1  memory completion, sampled only while mem_en=1.

Function
REQ-018 FSM states: IDLE, BUSY; all outputs registered.
REQ-019 IDLE: if any req is high at a rising edge, grant one master, latch its addr/wdata/we into internal registers, and enter BUSY.
REQ-020 Arbitration is round-robin: if both req are high, grant the master not granted last. If only one req is high, grant that master.
REQ-021 A last_grant register records the granted master, updated on every grant.
REQ-022 BUSY: mem_en=1; mem_address, mem_datao and mem_rw=~we are driven from the latched registers and are stable for the whole of BUSY.
REQ-023 Outside BUSY, mem_en=0, and mem_address, mem_datao and mem_rw hold their last values.
REQ-024 Latency: req seen at edge N puts mem_en high from edge N. mem_ready=1 at edge M gives done=1 for the single cycle after M, with state back to IDLE.
REQ-025 Read completion: the granted master's rdata is loaded with mem_data at edge M. Write completion: rdata is unchanged.
REQ-026 Done for the non-granted master stays 0; only one done is high in any cycle.
REQ-027 wait_cnt (8 bit): cleared on entering BUSY; incremented on each BUSY cycle with mem_ready=0.
REQ-028 Abort: when wait_cnt reaches MAX_WAIT with mem_ready still 0, the FSM returns to IDLE. The granted master gets done=1, err=1, and rdata=32'hFFFFFFFF.
REQ-029 err=0 on every normal completion.
REQ-030 If mem_ready=1 in the same cycle that wait_cnt reaches MAX_WAIT, the transfer completes normally with err=0.
REQ-031 Dropping req during BUSY does not cancel the transfer; it completes and done still pulses.
REQ-032 After done, the FSM spends at least one cycle in IDLE before the next grant. The arbiter re-arbitrates at that IDLE edge, so a master holding req high is eligible again.
REQ-033 No combinational path exists from any input to any output.

Reset
REQ-034 reset low asynchronously forces: state=IDLE, last_grant=1 (so m0 wins the first tie), wait_cnt=0, mem_en=0, mem_address=0, mem_datao=0, mem_rw=1, m0/m1_rdata=0, m0/m1_done=0, m0/m1_err=0.
REQ-035 reset asserted mid-BUSY abandons the transfer and no done is issued.
REQ-036 After reset deasserts, the first grant can occur at the first rising edge.

Verification
REQ-037 After reset, m0 read addr 0x10, mem_ready high on the 2nd BUSY cycle with mem_data=0xDEADBEEF -> mem_rw=1, mem_address=0x10, then m0_done one cycle with m0_rdata=0xDEADBEEF and m0_err=0.
REQ-038 m0_req and m1_req both held high for 4 transfers, mem_ready always 1 -> grants m0, m1, m0, m1; each done pulses once; no cycle has both done high.
REQ-039 m1 write addr 0x20, wdata 0x12345678 -> mem_rw=0, mem_datao=0x12345678 throughout BUSY; m1_done pulses; m1_rdata unchanged.
REQ-040 MAX_WAIT=15, mem_ready held 0 -> after 15 BUSY cycles: m0_done=1, m0_err=1, m0_rdata=0xFFFFFFFF, mem_en=0 on the next cycle.
REQ-041 reset pulsed low during BUSY -> all outputs take their REQ-034 values immediately and no done follows; a subsequent m1 request is served normally.
REQ-042 m0_req dropped on the 1st BUSY cycle, mem_ready on the 3rd -> transfer completes and m0_done pulses once.
